// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: machine word/tag sizes, functional-unit
// indices and the reserved "no RS entry" tag.
package cdb_arbiter_pkg;

    localparam int WORD_SIZE = 32;
    localparam int UNIT_SIZE = 8;

    localparam int NUM_UNITS = 5;
    localparam int UNIT_LW   = 0;
    localparam int UNIT_SW   = 1;
    localparam int UNIT_ADD  = 2;
    localparam int UNIT_MUL  = 3;
    localparam int UNIT_MV   = 4;

    localparam logic [UNIT_SIZE-1:0] TAG_NONE = '0;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin picker: searches i_req starting at i_ptr (wrapping) and returns the
// first set bit as a one-hot grant plus its index. Purely combinational.
module cdb_arbiter_rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0] w_sum;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            // Rotated index (ptr + k) mod N, computed one bit wider to catch the wrap.
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N))
                w_sum = w_sum - (IDX_W+1)'(N);
            if (!o_any && i_req[w_sum[IDX_W-1:0]]) begin
                o_any                    = 1'b1;
                o_grant[w_sum[IDX_W-1:0]] = 1'b1;
                o_idx                    = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one round-robin grant per cycle, winner broadcast on a
// registered CDB. Optional grant/conflict counters under CDB_ARBITER_STATS_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_UNITS,
    parameter int TAG_W   = UNIT_SIZE,
    parameter int DATA_W  = WORD_SIZE
`ifdef CDB_ARBITER_STATS_EN
    ,parameter int STAT_W = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src
`ifdef CDB_ARBITER_STATS_EN
    ,output logic [NUM_REQ*STAT_W-1:0] stat_grant,
    output logic [STAT_W-1:0]          stat_conflict
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_any;
    logic [TAG_W-1:0]   w_tag;
    logic [DATA_W-1:0]  w_data;

    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_vld_p1;
    logic [TAG_W-1:0]   r_tag_p1;
    logic [DATA_W-1:0]  r_data_p1;
    logic [IDX_W-1:0]   r_src_p1;

    cdb_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // One-hot mux of the winning tag/data; no index arithmetic on the packed buses.
    always_comb begin
        w_tag  = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_tag  = w_tag  | req_tag[i*TAG_W +: TAG_W];
                w_data = w_data | req_data[i*DATA_W +: DATA_W];
            end
        end
        w_ptr_nxt = (w_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
    end

    assign req_ready = rst ? '0 : w_grant;

    // Stage p1: registered CDB broadcast and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_tag_p1  <= '0;
            r_data_p1 <= '0;
            r_src_p1  <= '0;
            r_rr_ptr  <= '0;
        end else if (w_any) begin
            // A flushed handshake is still consumed and still moves the pointer.
            r_vld_p1  <= !flush;
            r_tag_p1  <= w_tag;
            r_data_p1 <= w_data;
            r_src_p1  <= w_idx;
            r_rr_ptr  <= w_ptr_nxt;
        end else begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign cdb_valid = r_vld_p1;
    assign cdb_tag   = r_tag_p1;
    assign cdb_data  = r_data_p1;
    assign cdb_src   = r_src_p1;

`ifdef CDB_ARBITER_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] r_stat_grant;
    logic [STAT_W-1:0]         r_stat_conflict;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_grant    <= '0;
            r_stat_conflict <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i])
                    r_stat_grant[i*STAT_W +: STAT_W] <= sat_inc(r_stat_grant[i*STAT_W +: STAT_W]);
            end
            if ($countones(req_valid) > 1)
                r_stat_conflict <= sat_inc(r_stat_conflict);
        end
    end

    assign stat_grant    = r_stat_grant;
    assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) between the functional units fed by RS: load, store, add, mul, mv.
- Each finished unit presents a tag (RS entry / unit id) and a 32-bit result.
- Grants one requester per cycle, round-robin, and broadcasts the winner on a registered CDB.
- RS and the register file snoop the CDB to wake dependants and retire values.

Parameters:
- NUM_REQ, 5, number of requesting functional units; index 0 = lw, 1 = sw, 2 = add, 3 = mul, 4 = mv.
- TAG_W, 8, tag width; equals `UNIT_SIZE.
- DATA_W, 32, result width; equals `WORD_SIZE.
- STAT_W, 16, width of each statistics counter (used only under the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous; drops the CDB broadcast currently being registered.
- req_valid  in  NUM_REQ  per-unit result pending.
- req_tag  in  NUM_REQ*TAG_W  packed tags; unit i occupies bits [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  packed results, same packing as req_tag.
- req_ready  out  NUM_REQ  one-hot grant; the transfer happens when valid and ready are both high in a cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast value.
- cdb_src  out  $clog2(NUM_REQ)  index of the broadcasting unit.

Behaviour:
- Reset:
  - Applied at posedge clk while rst=1.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
  - req_ready is 0 while rst=1.
  - Reset mid-transfer discards the registered broadcast. A requester that was granted in the reset cycle must re-present its result.
- Grant (combinational from req_valid and rr_ptr):
  - Search indices rr_ptr, rr_ptr+1, … mod NUM_REQ; the first valid one wins.
  - req_ready is one-hot or all-zero.
  - req_ready never depends on cdb state, so there is no back-pressure from the bus.
- Transfer at posedge when winner w exists and rst=0:
  - cdb_valid=1, cdb_tag=req_tag[w], cdb_data=req_data[w], cdb_src=w.
  - rr_ptr = (w+1) mod NUM_REQ.
- No winner: cdb_valid=0 next cycle; cdb_tag, cdb_data and cdb_src hold their previous values; rr_ptr unchanged.
- Latency: exactly 1 cycle from handshake to cdb_valid. Throughput is 1 broadcast per cycle.
- Requester rule: tag and data must stay stable while valid=1 and ready=0. Valid may drop only after a handshake. Violating this is a protocol error; the bench flags it and RTL does not check it.
- Fairness:
  - A continuously valid requester is granted within NUM_REQ cycles.
  - With all units valid, the grant order is 0,1,2,3,4,0,…
- Single requester: granted every cycle it is valid, regardless of rr_ptr.
- flush=1:
  - The handshake in that cycle still completes (the unit's result is considered consumed).
  - cdb_valid=0 next cycle; rr_ptr still advances.
  - flush and rst together: rst dominates.
- Tag 0 is reserved (no RS entry). A request with tag 0 is broadcast unchanged; RS ignores it.

Optional Feature:
- Macro: CDB_ARBITER_STATS_EN.
- Defined:
  - Adds output stat_grant (NUM_REQ*STAT_W): per-unit count of grants.
  - Adds output stat_conflict (STAT_W): count of cycles with two or more req_valid set.
  - Counters clear on rst, saturate at all-ones and are not affected by flush.
- Undefined: none of these ports or registers exist. The arbiter behaves identically otherwise.

Decomposition:
- Shared package/define file (alongside `WORD_SIZE/`UNIT_SIZE) holds:
  - unit index constants UNIT_LW=0, UNIT_SW=1, UNIT_ADD=2, UNIT_MUL=3, UNIT_MV=4;
  - NUM_UNITS=5;
  - the reserved tag value TAG_NONE=0.
- One sub-module, rr_pick: a purely combinational rotate, priority-encode and un-rotate.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
  - Reusable later for the RS issue select.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all req_valid=0 → cdb_valid=0, req_ready=0, rr_ptr=0.
- Single request: unit 2 valid, tag=8'h05, data=32'hDEADBEEF → req_ready=5'b00100 the same cycle; next cycle cdb_valid=1, tag 05, data DEADBEEF, src=2.
- Full contention: all 5 valid and held after each grant (new data each time) → grants 0,1,2,3,4,0 on consecutive cycles; cdb_src follows one cycle later.
- Pointer wrap: rr_ptr=4 (after granting unit 3), units 0 and 4 valid → unit 4 granted, then unit 0.
- Flush: unit 3 handshakes with data 32'h00000007 while flush=1 → next cycle cdb_valid=0; rr_ptr=4; unit 3 is not re-granted.
- Stats (with CDB_ARBITER_STATS_EN): 10 cycles with units 0 and 1 both always valid → stat_grant[0]=5, stat_grant[1]=5, stat_conflict=10; rst clears all to 0.
